// File: rtl/benes_route_sequencer_pkg.sv
// Shared constants and types for the Benes route-control sequencer.
// Network geometry, permutation table sizing and the route request record.
package benes_route_sequencer_pkg;

    localparam int unsigned SIZE       = 32;
    localparam int unsigned SWITCH_NUM = SIZE / 2;
    localparam int unsigned LOG_SIZE   = $clog2(SIZE);
    localparam int unsigned STAGE_NUM  = 2 * LOG_SIZE - 1;
    localparam int unsigned CFG_DEPTH  = 8;
    localparam int unsigned ID_W       = $clog2(CFG_DEPTH);
    localparam int unsigned CYCLES     = 2;
    localparam int unsigned STAGE_W    = 4;

    typedef enum logic {
        NET_MODULE = 1'b0,
        NET_SLOT   = 1'b1
    } net_e;

    typedef struct packed {
        logic [ID_W-1:0] mod_id;
        logic [ID_W-1:0] slot_id;
    } RouteReq;

    function automatic logic stage_in_range(input logic [STAGE_W-1:0] stage);
        return 32'(stage) < STAGE_NUM;
    endfunction

    // Table ID a route uses in the given network.
    function automatic logic [ID_W-1:0] route_id(input RouteReq r, input logic net);
        return (net_e'(net) == NET_SLOT) ? r.slot_id : r.mod_id;
    endfunction

endpackage

// File: rtl/benes_route_table.sv
// Dual-network switch-setting register file: one write port, one read port per stage.
// Out-of-range stage writes are dropped here as well as by the caller.
module benes_route_table
    import benes_route_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic                  wr_net_i,
    input  logic [ID_W-1:0]       wr_id_i,
    input  logic [STAGE_W-1:0]    wr_stage_i,
    input  logic [SWITCH_NUM-1:0] wr_data_i,
    input  logic [ID_W-1:0]       rd_mod_id_i   [STAGE_NUM],
    input  logic [ID_W-1:0]       rd_slot_id_i  [STAGE_NUM],
    output logic [SWITCH_NUM-1:0] rd_mod_data_o [STAGE_NUM],
    output logic [SWITCH_NUM-1:0] rd_slot_data_o[STAGE_NUM]
);

    logic [SWITCH_NUM-1:0] tbl_q [2][CFG_DEPTH][STAGE_NUM];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_q <= '{default: '0};
        end else if (wr_en_i && stage_in_range(wr_stage_i)) begin
            tbl_q[wr_net_i][wr_id_i][wr_stage_i] <= wr_data_i;
        end
    end

    for (genvar g = 0; g < STAGE_NUM; g++) begin : g_rd
        assign rd_mod_data_o[g]  = tbl_q[0][rd_mod_id_i[g]][g];
        assign rd_slot_data_o[g] = tbl_q[1][rd_slot_id_i[g]][g];
    end

endmodule

// File: rtl/benes_route_sequencer.sv
// Route-control sequencer feeding per-stage switch settings to the Benes network,
// skewed one cycle per stage so each setting tracks the data through the pipe.
module benes_route_sequencer
    import benes_route_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_wr_en,
    output logic                  cfg_wr_ready,
    input  logic                  cfg_wr_net,
    input  logic [ID_W-1:0]       cfg_wr_id,
    input  logic [STAGE_W-1:0]    cfg_wr_stage,
    input  logic [SWITCH_NUM-1:0] cfg_wr_data,
    output logic                  cfg_err,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ID_W-1:0]       req_mod_id,
    input  logic [ID_W-1:0]       req_slot_id,
    input  logic                  flush,
    output logic [SWITCH_NUM-1:0] o_module_select [0:STAGE_NUM-1],
    output logic [SWITCH_NUM-1:0] o_slot_select   [0:STAGE_NUM-1],
    output logic [STAGE_NUM-1:0]  o_stage_valid,
    output logic                  o_launch,
    output logic                  o_busy
);

    localparam int unsigned     CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    RouteReq               iss_q, iss_d;
    RouteReq               req_in;
    RouteReq               stg_q [STAGE_NUM];
    RouteReq               stg_d [STAGE_NUM];
    logic [STAGE_NUM-1:0]  vld_q, vld_d;
    logic [STAGE_NUM-1:0]  stage_hit;
    logic                  launch_q;
    logic                  err_q;
    logic                  accept;
    logic                  stage_ok;
    logic                  hazard;
    logic                  tbl_wr;

    logic [ID_W-1:0]       rd_mod_id  [STAGE_NUM];
    logic [ID_W-1:0]       rd_slot_id [STAGE_NUM];
    logic [SWITCH_NUM-1:0] mod_rd     [STAGE_NUM];
    logic [SWITCH_NUM-1:0] slot_rd    [STAGE_NUM];
    logic [SWITCH_NUM-1:0] mod_sel_q  [STAGE_NUM];
    logic [SWITCH_NUM-1:0] slot_sel_q [STAGE_NUM];

    assign req_in    = '{mod_id: req_mod_id, slot_id: req_slot_id};
    assign req_ready = !flush && (cnt_q == '0);
    assign accept    = req_valid && req_ready;

    // An entry is locked while any live or just-accepted route references it.
    assign stage_ok     = stage_in_range(cfg_wr_stage);
    assign hazard       = (|stage_hit)
                        || ((cnt_q != '0) && (route_id(iss_q, cfg_wr_net) == cfg_wr_id))
                        || (accept && (route_id(req_in, cfg_wr_net) == cfg_wr_id));
    assign cfg_wr_ready = !stage_ok || !hazard;
    assign tbl_wr       = cfg_wr_en && cfg_wr_ready && stage_ok;

    always_comb begin
        cnt_d = cnt_q;
        iss_d = iss_q;
        if (flush) begin
            cnt_d = '0;
            iss_d = '0;
        end else if (accept) begin
            cnt_d = CNT_LOAD;
            iss_d = req_in;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            iss_q    <= '0;
            stg_q    <= '{default: '0};
            vld_q    <= '0;
            launch_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            iss_q    <= iss_d;
            stg_q    <= stg_d;
            vld_q    <= vld_d;
            launch_q <= accept;
            if (cfg_wr_en && !stage_ok) begin
                err_q <= 1'b1;
            end
        end
    end

    // Select registers are loaded from the next-state pipe so they line up with vld_q.
    for (genvar g = 0; g < STAGE_NUM; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign stg_d[g] = accept ? req_in : iss_q;
            assign vld_d[g] = !flush && (accept || (cnt_q != '0));
        end else begin : g_tail
            assign stg_d[g] = stg_q[g-1];
            assign vld_d[g] = !flush && vld_q[g-1];
        end

        assign rd_mod_id[g]  = stg_d[g].mod_id;
        assign rd_slot_id[g] = stg_d[g].slot_id;
        assign stage_hit[g]  = vld_q[g] && (route_id(stg_q[g], cfg_wr_net) == cfg_wr_id);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mod_sel_q[g]  <= '0;
                slot_sel_q[g] <= '0;
            end else begin
                mod_sel_q[g]  <= vld_d[g] ? mod_rd[g]  : '0;
                slot_sel_q[g] <= vld_d[g] ? slot_rd[g] : '0;
            end
        end

        assign o_module_select[g] = mod_sel_q[g];
        assign o_slot_select[g]   = slot_sel_q[g];
    end

    benes_route_table u_table (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en_i        (tbl_wr),
        .wr_net_i       (cfg_wr_net),
        .wr_id_i        (cfg_wr_id),
        .wr_stage_i     (cfg_wr_stage),
        .wr_data_i      (cfg_wr_data),
        .rd_mod_id_i    (rd_mod_id),
        .rd_slot_id_i   (rd_slot_id),
        .rd_mod_data_o  (mod_rd),
        .rd_slot_data_o (slot_rd)
    );

    assign o_stage_valid = vld_q;
    assign o_launch      = launch_q;
    assign o_busy        = (|vld_q) || (cnt_q != '0);
    assign cfg_err       = err_q;

endmodule

// File: tb/tb_benes_route_sequencer.sv
// Randomized bench for benes_route_sequencer against a timing-rule reference model.
// Routes are tracked by accept edge; stage occupancy is derived arithmetically.
module tb_benes_route_sequencer;
    import benes_route_sequencer_pkg::*;

    localparam int CYC = CYCLES;
    localparam int NST = STAGE_NUM;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  cfg_wr_en = 1'b0;
    logic                  cfg_wr_ready;
    logic                  cfg_wr_net = 1'b0;
    logic [ID_W-1:0]       cfg_wr_id = '0;
    logic [STAGE_W-1:0]    cfg_wr_stage = '0;
    logic [SWITCH_NUM-1:0] cfg_wr_data = '0;
    logic                  cfg_err;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic [ID_W-1:0]       req_mod_id = '0;
    logic [ID_W-1:0]       req_slot_id = '0;
    logic                  flush = 1'b0;
    logic [SWITCH_NUM-1:0] o_module_select [0:STAGE_NUM-1];
    logic [SWITCH_NUM-1:0] o_slot_select   [0:STAGE_NUM-1];
    logic [STAGE_NUM-1:0]  o_stage_valid;
    logic                  o_launch;
    logic                  o_busy;

    always #5 clk = ~clk;

    benes_route_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_wr_en       (cfg_wr_en),
        .cfg_wr_ready    (cfg_wr_ready),
        .cfg_wr_net      (cfg_wr_net),
        .cfg_wr_id       (cfg_wr_id),
        .cfg_wr_stage    (cfg_wr_stage),
        .cfg_wr_data     (cfg_wr_data),
        .cfg_err         (cfg_err),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_mod_id      (req_mod_id),
        .req_slot_id     (req_slot_id),
        .flush           (flush),
        .o_module_select (o_module_select),
        .o_slot_select   (o_slot_select),
        .o_stage_valid   (o_stage_valid),
        .o_launch        (o_launch),
        .o_busy          (o_busy)
    );

    typedef struct {
        int t;
        int m;
        int s;
    } route_t;

    route_t                routes[$];
    logic [SWITCH_NUM-1:0] mtab [2][CFG_DEPTH][STAGE_NUM];
    int                    edge_n = 0;
    int                    t_last = -1000;
    bit                    err_m = 1'b0;
    int                    n_tests = 0;
    int                    n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        routes.delete();
        t_last = -1000;
        err_m  = 1'b0;
        for (int n = 0; n < 2; n++)
            for (int i = 0; i < CFG_DEPTH; i++)
                for (int s = 0; s < NST; s++)
                    mtab[n][i][s] = '0;
    endtask

    // Compare every registered output with the model state after edge edge_n.
    task automatic check_outputs();
        logic [STAGE_NUM-1:0] ev;
        ev = '0;
        for (int s = 0; s < NST; s++) begin
            int idx;
            logic [SWITCH_NUM-1:0] em, es;
            idx = -1;
            foreach (routes[i]) begin
                int d;
                d = edge_n - routes[i].t - s;
                if (d >= 0 && d < CYC) idx = i;
            end
            em = '0;
            es = '0;
            if (idx >= 0) begin
                ev[s] = 1'b1;
                em = mtab[0][routes[idx].m][s];
                es = mtab[1][routes[idx].s][s];
            end
            check($sformatf("module_select[%0d]", s), 64'(o_module_select[s]), 64'(em));
            check($sformatf("slot_select[%0d]", s), 64'(o_slot_select[s]), 64'(es));
        end
        check("stage_valid", 64'(o_stage_valid), 64'(ev));
        check("launch", 64'(o_launch), 64'(routes.size() > 0 && routes[$].t == edge_n));
        check("busy", 64'(o_busy), 64'(ev != '0));
        check("cfg_err", 64'(cfg_err), 64'(err_m));
    endtask

    // Called just after a negedge: drive, check handshakes, advance one edge, check outputs.
    task automatic step(input logic wen, input logic net, input logic [ID_W-1:0] wid,
                        input logic [STAGE_W-1:0] wstg, input logic [SWITCH_NUM-1:0] wdata,
                        input logic rv, input logic [ID_W-1:0] rm, input logic [ID_W-1:0] rs,
                        input logic fl);
        bit exp_rr, exp_wr, acc, hz, bad;
        cfg_wr_en    = wen;
        cfg_wr_net   = net;
        cfg_wr_id    = wid;
        cfg_wr_stage = wstg;
        cfg_wr_data  = wdata;
        req_valid    = rv;
        req_mod_id   = rm;
        req_slot_id  = rs;
        flush        = fl;
        #1;
        bad    = (int'(wstg) >= NST);
        exp_rr = !fl && (edge_n + 1 >= t_last + CYC);
        acc    = rv && exp_rr;
        hz     = 1'b0;
        foreach (routes[i])
            if (edge_n - routes[i].t <= CYC + NST - 2)
                if ((net ? routes[i].s : routes[i].m) == int'(wid)) hz = 1'b1;
        if (acc && ((net ? rs : rm) == wid)) hz = 1'b1;
        exp_wr = bad || !hz;
        check("req_ready", 64'(req_ready), 64'(exp_rr));
        check("cfg_wr_ready", 64'(cfg_wr_ready), 64'(exp_wr));
        @(posedge clk);
        edge_n++;
        if (fl) begin
            routes.delete();
            t_last = -1000;
        end
        if (acc) begin
            routes.push_back('{t: edge_n, m: int'(rm), s: int'(rs)});
            t_last = edge_n;
        end
        if (wen && exp_wr && !bad) mtab[net][wid][wstg] = wdata;
        if (wen && bad) err_m = 1'b1;
        while (routes.size() > 0 && edge_n - routes[0].t > CYC + NST) void'(routes.pop_front());
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        cfg_wr_en = 1'b0;
        req_valid = 1'b0;
        flush     = 1'b0;
        #2 rst_n  = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        #1;
        check("req_ready_after_reset", 64'(req_ready), 64'd1);
        check("cfg_wr_ready_after_reset", 64'(cfg_wr_ready), 64'd1);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_outputs();
        check("req_ready_in_reset", 64'(req_ready), 64'd1);
        check("cfg_wr_ready_in_reset", 64'(cfg_wr_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Program one word per network, then route through them.
        step(1'b1, 1'b0, 3'd3, 4'd0, 16'h0001, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b1, 3'd3, 4'd8, 16'h8000, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 3'd3, 3'd3, 1'b0);
        idle(12);

        // Back-to-back requests with an in-flight write hazard and a free-ID write.
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 3'd1, 3'd1, 1'b0);
        step(1'b1, 1'b0, 3'd1, 4'd4, 16'h00f0, 1'b1, 3'd2, 3'd2, 1'b0);
        step(1'b1, 1'b0, 3'd5, 4'd4, 16'h0f00, 1'b1, 3'd2, 3'd2, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 3'd1, 4'd4, 16'h00f0, 1'b0, '0, '0, 1'b0);

        // Bad stage write, then flush mid-route followed by a fresh request.
        step(1'b1, 1'b0, 3'd3, 4'd12, 16'hdead, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 3'd3, 3'd1, 1'b0);
        idle(3);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 3'd2, 3'd2, 1'b1);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 3'd1, 3'd3, 1'b0);
        idle(3);
        do_reset();
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 3'd3, 3'd3, 1'b0);
        idle(12);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                logic [STAGE_W-1:0] stg;
                stg = ($urandom_range(0, 19) == 0) ? STAGE_W'($urandom_range(9, 15))
                                                   : STAGE_W'($urandom_range(0, 8));
                step($urandom_range(0, 99) < 35, 1'($urandom_range(0, 1)),
                     ID_W'($urandom_range(0, CFG_DEPTH - 1)), stg, SWITCH_NUM'($urandom),
                     $urandom_range(0, 99) < 60, ID_W'($urandom_range(0, CFG_DEPTH - 1)),
                     ID_W'($urandom_range(0, CFG_DEPTH - 1)), $urandom_range(0, 49) == 0);
            end
        end
        idle(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
